fir_error_monitor: RTL and testbench
====================================

# fir_error_monitor

Run-time accuracy monitor for the shift-and-add 16-bit FIR built on approximate prefix adders. The block sits on the filter output and reads the same input stream `x` plus the filter's `dataout`. It keeps its own exact-arithmetic model of the 5-tap filter and compares the two on every clock over a programmable window. It reports mismatch count, summed absolute error and peak absolute error through a start/done handshake.

## Interface
- `WIN`, default 64: window length in samples; legal range 1..65535.
- `clk`  in  1  clock.
- `rst`  in  1  reset rst, synchronous, active-high; clock clk.
- `x`  in  16  filter input sample, the same value presented to the filter in the same cycle.
- `approx`  in  16  filter output `dataout`, same cycle as `x`.
- `start`  in  1  single-cycle request to arm a measurement window.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  level; high in DONE, results valid.
- `err_cnt`  out  16  number of samples with exact ≠ approx.
- `sum_abs`  out  32  Σ|exact − approx| over the window.
- `max_abs`  out  16  max |exact − approx| over the window.

## Operation
- Delay line `d1..d4` holds `x` delayed 1..4 cycles. It updates on every clock regardless of FSM state, mirroring the filter registers. It resets to 0.
- Exact model: `exact = (x>>5) + (d1>>4) + (d2>>3) + (d3>>2) + (d4>>1)`. Shifts are logical. The sum is taken modulo 2^16 with no rounding.
- Error: `diff = {1'b0,exact} − {1'b0,approx}`, 17-bit signed. `abs` is the 16-bit magnitude, max 65535.
- Stage 1 (register): `abs_s1`, `mis_s1 = (exact != approx)`, `vld_s1 = (state==RUN)`.
- Stage 2 (accumulate, when `vld_s1`): `err_cnt += mis_s1`, `sum_abs += abs_s1`, `max_abs = max(max_abs, abs_s1)`.
- 32-bit `sum_abs` cannot overflow because 65535 × 65535 < 2^32. No saturation logic.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: on `start`, go to RUN. Clear accumulators, stage-1 valid and sample counter.
  - RUN: one sample per clock. The counter increments each edge. After the WIN-th sample edge, go to DRAIN.
  - DRAIN: one cycle so the last stage-1 result accumulates, then go to DONE.
  - DONE: results held and `done`=1. On `start`, clear and go to RUN, exactly as from IDLE.
- `start` in RUN or DRAIN is ignored.
- Results stay readable in IDLE after reset (all 0) and in DONE until re-armed. During RUN they show partial values and must not be sampled.

## Timing
- Reset: state IDLE, `busy`=0, `done`=0, `err_cnt`=0, `sum_abs`=0, `max_abs`=0, delay line and stage-1 regs 0.
- `rst` mid-RUN or mid-DRAIN aborts the window. The next edge gives full reset values and no partial result is kept.
- `start` sampled high at edge E0, in IDLE or DONE:
  - At E0: state RUN, accumulators cleared, `busy`=1 and `done`=0 from E0.
  - Sample k (k=1..WIN) is the `x`/`approx` pair present before edge E0+k. It is registered at E0+k and accumulated at E0+k+1.
  - E0+WIN: state DRAIN.
  - E0+WIN+1: last accumulate, state DONE, `done`=1, `busy`=0.
- Result latency: WIN+1 edges from start edge to `done`.
- The pair present in the start cycle itself is not counted.
- WIN=1: RUN lasts one edge, and `done` is high after E0+2.
- `start` and `rst` in the same cycle: `rst` wins.

## Test plan
- Reset: hold `rst` 2 cycles → all outputs 0, `busy`=0, `done`=0; `start` not asserted → stays IDLE indefinitely.
- Matched stream: WIN=64, ramp `x`=0..200, `approx` driven from a bench exact model → `done` exactly 65 edges after start; `err_cnt`=0, `sum_abs`=0, `max_abs`=0.
- Full-scale mismatch: WIN=8, `x`=16'hFFFF held ≥4 cycles before start, `approx`=0 → exact=16'hF7FB; `err_cnt`=8, `sum_abs`=507864, `max_abs`=16'hF7FB.
- Single injected error: WIN=16, matched stream with sample 5 driven as `approx`=exact^16'h0040 → `err_cnt`=1, `sum_abs`=64, `max_abs`=64.
- Control hazards:
  - `start` pulsed during RUN → window length unchanged, `done` timing unchanged.
  - `rst` at sample 10 → all outputs 0 next cycle, FSM in IDLE.
- Re-arm: from DONE with nonzero results, pulse `start` with a matched stream → results clear at the start edge; new window gives `err_cnt`=0 and `done` after WIN+1 edges.

Source files
------------

// File: rtl/fir_error_monitor.sv
// fir_error_monitor
//   Run-time accuracy monitor for the 5-tap shift-and-add FIR built on
//   approximate adders. Keeps an exact-arithmetic copy of the filter, compares
//   it with the filter output every clock over a WIN-sample window, and reports
//   mismatch count, summed absolute error and peak absolute error.
//
// Ports
//   clk      in   1   clock
//   rst      in   1   synchronous active-high reset
//   x        in  16   filter input sample (same cycle as the filter sees it)
//   approx   in  16   filter dataout, same cycle as x
//   start    in   1   single-cycle request to arm a window (IDLE/DONE only)
//   busy     out  1   high in RUN and DRAIN
//   done     out  1   high in DONE, results valid
//   err_cnt  out 16   samples where exact != approx
//   sum_abs  out 32   sum of |exact - approx|
//   max_abs  out 16   max of |exact - approx|
module fir_error_monitor #(
  parameter int WIN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] x,
  input  logic [15:0] approx,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] err_cnt,
  output logic [31:0] sum_abs,
  output logic [15:0] max_abs
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [15:0] LAST = 16'(WIN - 1);

  state_t      state;
  logic [15:0] cnt_reg;

  // Delay line mirroring the filter's own registers.
  logic [15:0] d1_reg, d2_reg, d3_reg, d4_reg;

  logic [15:0] abs_s1_reg;
  logic        mis_s1_reg;
  logic        vld_s1_reg;

  logic [15:0] exact;
  logic [16:0] diff;
  logic [16:0] neg_diff;
  logic [15:0] abs_val;

  // Exact model: logical shifts, sum wraps modulo 2^16.
  assign exact = (x >> 5) + (d1_reg >> 4) + (d2_reg >> 3) + (d3_reg >> 2) + (d4_reg >> 1);

  // 17-bit signed difference; magnitude always fits in 16 bits.
  assign diff     = {1'b0, exact} - {1'b0, approx};
  assign neg_diff = 17'd0 - diff;
  assign abs_val  = diff[16] ? neg_diff[15:0] : diff[15:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt_reg    <= '0;
      d1_reg     <= '0;
      d2_reg     <= '0;
      d3_reg     <= '0;
      d4_reg     <= '0;
      abs_s1_reg <= '0;
      mis_s1_reg <= 1'b0;
      vld_s1_reg <= 1'b0;
      err_cnt    <= '0;
      sum_abs    <= '0;
      max_abs    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      d1_reg <= x;
      d2_reg <= d1_reg;
      d3_reg <= d2_reg;
      d4_reg <= d3_reg;

      // Stage 1: register the comparison; only RUN-cycle samples are valid.
      abs_s1_reg <= abs_val;
      mis_s1_reg <= (exact != approx);
      vld_s1_reg <= (state == RUN);

      // Stage 2: accumulate. Clears in the arm branch below take priority.
      if (vld_s1_reg) begin
        err_cnt <= err_cnt + {15'd0, mis_s1_reg};
        sum_abs <= sum_abs + {16'd0, abs_s1_reg};
        if (abs_s1_reg > max_abs) begin
          max_abs <= abs_s1_reg;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            cnt_reg    <= '0;
            vld_s1_reg <= 1'b0;  // the start-cycle pair is never counted
            err_cnt    <= '0;
            sum_abs    <= '0;
            max_abs    <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        RUN: begin
          cnt_reg <= cnt_reg + 16'd1;
          if (cnt_reg == LAST) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // Last stage-1 result lands in the accumulators on this edge.
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_error_monitor.sv
// tb_fir_error_monitor
//   Randomized bench for fir_error_monitor. Four instances with WIN = 64, 8,
//   16 and 1 share x/approx/rst; sel chooses which one gets start and is
//   checked. Expected results come from the filter equation applied to a
//   history of presented x values plus plain error arithmetic.
module tb_fir_error_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] x;
  logic [15:0] approx;
  logic [3:0]  start_v;
  logic [3:0]  busy_v;
  logic [3:0]  done_v;
  logic [15:0] err_v [4];
  logic [31:0] sum_v [4];
  logic [15:0] max_v [4];

  int errors = 0;
  int checks = 0;
  int sel    = 0;
  int ramp   = 0;
  int win_of [4] = '{64, 8, 16, 1};

  // h[k] = x value presented k clocks ago (zero after reset)
  logic [15:0] h [1:4];

  always #5 clk = ~clk;

  fir_error_monitor #(.WIN(64)) u_w64 (
    .clk(clk), .rst(rst), .x(x), .approx(approx), .start(start_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .err_cnt(err_v[0]), .sum_abs(sum_v[0]), .max_abs(max_v[0])
  );
  fir_error_monitor #(.WIN(8)) u_w8 (
    .clk(clk), .rst(rst), .x(x), .approx(approx), .start(start_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .err_cnt(err_v[1]), .sum_abs(sum_v[1]), .max_abs(max_v[1])
  );
  fir_error_monitor #(.WIN(16)) u_w16 (
    .clk(clk), .rst(rst), .x(x), .approx(approx), .start(start_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .err_cnt(err_v[2]), .sum_abs(sum_v[2]), .max_abs(max_v[2])
  );
  fir_error_monitor #(.WIN(1)) u_w1 (
    .clk(clk), .rst(rst), .x(x), .approx(approx), .start(start_v[3]),
    .busy(busy_v[3]), .done(done_v[3]), .err_cnt(err_v[3]), .sum_abs(sum_v[3]), .max_abs(max_v[3])
  );

  function automatic logic [15:0] exact_now(input logic [15:0] xv);
    int s;
    s = int'(xv >> 5) + int'(h[1] >> 4) + int'(h[2] >> 3) + int'(h[3] >> 2) + int'(h[4] >> 1);
    return s[15:0];
  endfunction

  // One clock: drive inputs, take the edge, update history, settle.
  task automatic step(input logic [15:0] xv, input logic [15:0] av, input logic st);
    x       = xv;
    approx  = av;
    start_v = '0;
    start_v[sel] = st;
    @(posedge clk);
    if (rst) begin
      for (int i = 1; i <= 4; i++) h[i] = '0;
    end else begin
      h[4] = h[3];
      h[3] = h[2];
      h[2] = h[1];
      h[1] = xv;
    end
    #1;
    start_v = '0;
  endtask

  task automatic gen_x(input int mode, output logic [15:0] xv);
    case (mode)
      0: begin
        xv   = ramp[15:0];
        ramp = ramp + 1;
      end
      3:       xv = 16'hFFFF;
      default: xv = 16'($urandom);
    endcase
  endtask

  // mode 0 ramp matched, 1 random matched, 2 random mixed, 3 full-scale vs 0.
  // inj: sample index whose approx gets bit 6 flipped (0 = none).
  task automatic run_window(input int mode, input int inj, input logic mid_start,
                            output int ecnt, output logic [31:0] esum, output int emax);
    int          win;
    int          dd;
    logic [15:0] xv, av, e;
    win  = win_of[sel];
    ecnt = 0;
    esum = '0;
    emax = 0;

    gen_x(mode, xv);
    av = 16'($urandom);
    step(xv, av, 1'b1);
    checks++;
    if (busy_v[sel] !== 1'b1 || done_v[sel] !== 1'b0 || err_v[sel] !== 16'd0 ||
        sum_v[sel] !== 32'd0 || max_v[sel] !== 16'd0) begin
      errors++;
      $display("FAIL start_clear win=%0d: busy=%0b done=%0b err=%0d sum=%0d max=%0d, required busy=1 done=0 err=0 sum=0 max=0",
               win, busy_v[sel], done_v[sel], err_v[sel], sum_v[sel], max_v[sel]);
    end

    for (int k = 1; k <= win; k++) begin
      gen_x(mode, xv);
      e = exact_now(xv);
      case (mode)
        0, 1:    av = e;
        2:       av = ($urandom_range(0, 2) == 0) ? e : 16'($urandom);
        default: av = 16'd0;
      endcase
      if (k == inj) av = e ^ 16'h0040;
      dd = int'(e) - int'(av);
      if (dd < 0) dd = -dd;
      if (e != av) ecnt++;
      esum = esum + 32'(dd);
      if (dd > emax) emax = dd;
      step(xv, av, mid_start && (k == 3));
      if (k < win) begin
        checks++;
        if (busy_v[sel] !== 1'b1 || done_v[sel] !== 1'b0) begin
          errors++;
          $display("FAIL run_state win=%0d k=%0d: busy=%0b done=%0b, required busy=1 done=0",
                   win, k, busy_v[sel], done_v[sel]);
        end
      end
    end

    checks++;
    if (busy_v[sel] !== 1'b1 || done_v[sel] !== 1'b0) begin
      errors++;
      $display("FAIL drain_state win=%0d: busy=%0b done=%0b, required busy=1 done=0",
               win, busy_v[sel], done_v[sel]);
    end

    gen_x(mode, xv);
    step(xv, 16'($urandom), mid_start);
    checks++;
    if (busy_v[sel] !== 1'b0 || done_v[sel] !== 1'b1) begin
      errors++;
      $display("FAIL done_timing win=%0d: busy=%0b done=%0b, required busy=0 done=1",
               win, busy_v[sel], done_v[sel]);
    end
    checks++;
    if (err_v[sel] !== 16'(ecnt) || sum_v[sel] !== esum || max_v[sel] !== 16'(emax)) begin
      errors++;
      $display("FAIL results win=%0d: err=%0d sum=%0d max=%0d, required err=%0d sum=%0d max=%0d",
               win, err_v[sel], sum_v[sel], max_v[sel], ecnt, esum, emax);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(16'h1234, 16'h0, 1'b0);
    step(16'h5678, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || err_v[i] !== 16'd0 ||
          sum_v[i] !== 32'd0 || max_v[i] !== 16'd0) begin
        errors++;
        $display("FAIL reset_state inst=%0d: busy=%0b done=%0b err=%0d sum=%0d max=%0d, required all 0",
                 i, busy_v[i], done_v[i], err_v[i], sum_v[i], max_v[i]);
      end
    end
    rst = 1'b0;
    for (int n = 0; n < 80; n++) step(16'($urandom), 16'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || err_v[i] !== 16'd0) begin
        errors++;
        $display("FAIL idle_hold inst=%0d: busy=%0b done=%0b err=%0d, required 0 0 0",
                 i, busy_v[i], done_v[i], err_v[i]);
      end
    end
  endtask

  task automatic test_matched;
    int ec, em;
    logic [31:0] es;
    sel  = 0;
    ramp = 0;
    run_window(0, 0, 1'b0, ec, es, em);
    checks++;
    if (err_v[0] !== 16'd0 || sum_v[0] !== 32'd0 || max_v[0] !== 16'd0) begin
      errors++;
      $display("FAIL matched_zero: err=%0d sum=%0d max=%0d, required 0 0 0", err_v[0], sum_v[0], max_v[0]);
    end
  endtask

  task automatic test_full_scale;
    int ec, em;
    logic [31:0] es;
    sel = 1;
    for (int n = 0; n < 4; n++) step(16'hFFFF, 16'h0, 1'b0);
    run_window(3, 0, 1'b0, ec, es, em);
    checks++;
    if (err_v[1] !== 16'd8 || sum_v[1] !== 32'd507864 || max_v[1] !== 16'hF7FB) begin
      errors++;
      $display("FAIL full_scale: err=%0d sum=%0d max=%h, required err=8 sum=507864 max=f7fb",
               err_v[1], sum_v[1], max_v[1]);
    end
  endtask

  task automatic test_inject;
    int ec, em;
    logic [31:0] es;
    sel = 2;
    run_window(1, 5, 1'b0, ec, es, em);
    checks++;
    if (err_v[2] !== 16'd1 || sum_v[2] !== 32'd64 || max_v[2] !== 16'd64) begin
      errors++;
      $display("FAIL single_inject: err=%0d sum=%0d max=%0d, required 1 64 64", err_v[2], sum_v[2], max_v[2]);
    end
  endtask

  task automatic test_random;
    int ec, em;
    logic [31:0] es;
    sel = 2;
    for (int r = 0; r < 3; r++) run_window(2, 0, 1'b0, ec, es, em);
    sel = 0;
    run_window(2, 0, 1'b0, ec, es, em);
  endtask

  task automatic test_start_in_run;
    int ec, em;
    logic [31:0] es;
    sel = 2;
    run_window(2, 0, 1'b1, ec, es, em);
  endtask

  task automatic test_rearm;
    int ec, em;
    logic [31:0] es;
    sel = 1;
    run_window(2, 0, 1'b0, ec, es, em);
    for (int n = 0; n < 3; n++) step(16'($urandom), 16'($urandom), 1'b0);
    checks++;
    if (done_v[1] !== 1'b1 || err_v[1] !== 16'(ec) || sum_v[1] !== es || max_v[1] !== 16'(em)) begin
      errors++;
      $display("FAIL done_hold: done=%0b err=%0d sum=%0d max=%0d, required done=1 err=%0d sum=%0d max=%0d",
               done_v[1], err_v[1], sum_v[1], max_v[1], ec, es, em);
    end
    run_window(1, 0, 1'b0, ec, es, em);
    checks++;
    if (err_v[1] !== 16'd0) begin
      errors++;
      $display("FAIL rearm_matched: err=%0d, required 0", err_v[1]);
    end
  endtask

  task automatic test_win1;
    int ec, em;
    logic [31:0] es;
    sel = 3;
    for (int r = 0; r < 4; r++) run_window(2, 0, 1'b0, ec, es, em);
  endtask

  task automatic test_rst_mid;
    sel = 0;
    step(16'($urandom), 16'($urandom), 1'b1);
    for (int k = 1; k <= 9; k++) step(16'($urandom), 16'($urandom), 1'b0);
    rst = 1'b1;
    step(16'($urandom), 16'($urandom), 1'b0);
    rst = 1'b0;
    checks++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || err_v[0] !== 16'd0 ||
        sum_v[0] !== 32'd0 || max_v[0] !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_run: busy=%0b done=%0b err=%0d sum=%0d max=%0d, required all 0",
               busy_v[0], done_v[0], err_v[0], sum_v[0], max_v[0]);
    end
    for (int n = 0; n < 70; n++) step(16'($urandom), 16'($urandom), 1'b0);
    checks++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_idle: busy=%0b done=%0b, required 0 0", busy_v[0], done_v[0]);
    end
  endtask

  task automatic test_start_with_rst;
    sel = 2;
    rst = 1'b1;
    step(16'($urandom), 16'($urandom), 1'b1);
    rst = 1'b0;
    for (int n = 0; n < 20; n++) step(16'($urandom), 16'($urandom), 1'b0);
    checks++;
    if (busy_v[2] !== 1'b0 || done_v[2] !== 1'b0) begin
      errors++;
      $display("FAIL start_rst_same: busy=%0b done=%0b, required 0 0", busy_v[2], done_v[2]);
    end
  endtask

  initial begin
    for (int i = 1; i <= 4; i++) h[i] = '0;
    rst     = 1'b1;
    x       = '0;
    approx  = '0;
    start_v = '0;
    test_reset();
    test_matched();
    test_full_scale();
    test_inject();
    test_random();
    test_start_in_run();
    test_rearm();
    test_win1();
    test_rst_mid();
    test_start_with_rst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
